// File: rtl/cd_pkg.sv
// Shared definitions for the countdown timer controller: state encoding and
// default register width.
package cd_pkg;

  localparam int CD_W = 6;

  typedef enum logic [1:0] {
    CD_IDLE  = 2'd0,
    CD_RUN   = 2'd1,
    CD_PAUSE = 2'd2,
    CD_ALARM = 2'd3
  } cd_state_e;

endpackage

// File: rtl/cd_preset_counter.sv
// Saturating up/down preset register. Exposes the next value so the owner can
// mirror it into other registers on the same edge.
module cd_preset_counter #(
  parameter int W           = cd_pkg::CD_W,
  parameter int DEFAULT_SEC = 30,
  parameter int MAX_SEC     = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         hold,
  output logic [W-1:0] value,
  output logic [W-1:0] value_nxt
);

  always_comb begin
    // NOTE: default assignment first so every path drives value_nxt and no latch is inferred.
    value_nxt = value;
    if (!hold) begin
      if (inc && !dec && value < W'(MAX_SEC))
        value_nxt = value + 1'b1;
      else if (dec && !inc && value > W'(1))
        value_nxt = value - 1'b1;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous, active-low), and
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) value <= W'(DEFAULT_SEC);
    else      value <= value_nxt;
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: preset handling, run/pause/cancel control and a
// buzzer that sounds for a fixed number of ticks after expiry.
module countdown_ctrl
  import cd_pkg::*;
#(
  parameter int W           = CD_W,
  parameter int DEFAULT_SEC = 30,
  parameter int MAX_SEC     = 59,
  parameter int BUZZ_TICKS  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_1hz,
  input  logic         btn_start,
  input  logic         btn_pause,
  input  logic         btn_cancel,
  input  logic         btn_inc,
  input  logic         btn_dec,
  output logic [W-1:0] remaining,
  output logic [W-1:0] preset,
  output logic [1:0]   state,
  output logic         buzz,
  output logic         done
);

  localparam int BC_W = $clog2(BUZZ_TICKS + 1);

  cd_state_e         state_q;
  logic [BC_W-1:0]   buzz_cnt;
  logic [W-1:0]      preset_nxt;
  logic              preset_hold;

  // Start in the same cycle as inc/dec freezes the preset so the run uses the old value.
  assign preset_hold = (state_q != CD_IDLE) || btn_start;
  assign state       = state_q;

  cd_preset_counter #(
    .W           (W),
    .DEFAULT_SEC (DEFAULT_SEC),
    .MAX_SEC     (MAX_SEC)
  ) u_preset (
    .clk       (clk),
    .rst       (rst),
    .inc       (btn_inc),
    .dec       (btn_dec),
    .hold      (preset_hold),
    .value     (preset),
    .value_nxt (preset_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= CD_IDLE;
      remaining <= W'(DEFAULT_SEC);
      buzz      <= 1'b0;
      done      <= 1'b0;
      buzz_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        CD_IDLE: begin
          if (btn_start) begin
            state_q   <= CD_RUN;
            remaining <= preset;
          end else begin
            remaining <= preset_nxt;
          end
        end

        CD_RUN: begin
          if (btn_cancel) begin
            state_q   <= CD_IDLE;
            remaining <= preset;
          end else if (btn_pause) begin
            state_q <= CD_PAUSE;
          end else if (tick_1hz) begin
            if (remaining > W'(1)) begin
              remaining <= remaining - 1'b1;
            end else begin
              state_q   <= CD_ALARM;
              remaining <= '0;
              done      <= 1'b1;
              buzz      <= 1'b1;
              buzz_cnt  <= BC_W'(BUZZ_TICKS);
            end
          end
        end

        CD_PAUSE: begin
          if (btn_cancel) begin
            state_q   <= CD_IDLE;
            remaining <= preset;
          end else if (btn_start) begin
            state_q <= CD_RUN;
          end
        end

        CD_ALARM: begin
          // Silencing by button and the last buzzer tick share the same exit.
          if (btn_start || btn_cancel || (tick_1hz && buzz_cnt <= BC_W'(1))) begin
            state_q   <= CD_IDLE;
            remaining <= preset;
            buzz      <= 1'b0;
            buzz_cnt  <= '0;
          end else if (tick_1hz) begin
            buzz_cnt <= buzz_cnt - 1'b1;
          end
        end

        default: state_q <= CD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: a rule-level model predicts each cycle's
// outputs, a monitor compares them against the DUT one cycle later.
module tb_countdown_ctrl;

  localparam int DEF_SEC = 30;
  localparam int MAX_SEC = 59;
  localparam int BUZZ_N  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_cancel = 1'b0;
  logic       btn_inc = 1'b0, btn_dec = 1'b0;
  logic [5:0] remaining, preset;
  logic [1:0] state;
  logic       buzz, done;

  int checks = 0;
  int errors = 0;

  // Packed observation: {state[1:0], preset[5:0], remaining[5:0], buzz, done}
  logic [15:0] exp_q[$];

  // Reference model state, kept as plain integers.
  int m_mode = 0;  // 0 idle, 1 running, 2 paused, 3 alarming
  int m_pre  = DEF_SEC;
  int m_rem  = DEF_SEC;
  int m_left = 0;  // buzzer ticks still to sound
  int m_done = 0;

  countdown_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_cancel (btn_cancel),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .remaining  (remaining),
    .preset     (preset),
    .state      (state),
    .buzz       (buzz),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got st=%0d pre=%0d rem=%0d buzz=%0b done=%0b, expected st=%0d pre=%0d rem=%0d buzz=%0b done=%0b",
               name, $time, act[15:14], act[13:8], act[7:2], act[1], act[0],
               exp[15:14], exp[13:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [15:0] model_obs();
    logic [1:0] s = 2'(m_mode);
    logic [5:0] p = 6'(m_pre);
    logic [5:0] r = 6'(m_rem);
    return {s, p, r, (m_mode == 3) ? 1'b1 : 1'b0, (m_done != 0) ? 1'b1 : 1'b0};
  endfunction

  // Behavioural rules, applied once per clock to the sampled inputs.
  task automatic model_step(input bit r, t, s, p, c, i, d);
    m_done = 0;
    if (!r) begin
      m_mode = 0; m_pre = DEF_SEC; m_rem = DEF_SEC; m_left = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (s) begin
          m_mode = 1; m_rem = m_pre;
        end else begin
          if (i && !d) m_pre = (m_pre + 1 > MAX_SEC) ? MAX_SEC : m_pre + 1;
          if (d && !i) m_pre = (m_pre - 1 < 1) ? 1 : m_pre - 1;
          m_rem = m_pre;
        end
      end
      1: begin
        if (c) begin
          m_mode = 0; m_rem = m_pre;
        end else if (p) begin
          m_mode = 2;
        end else if (t) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_mode = 3; m_done = 1; m_left = BUZZ_N;
          end
        end
      end
      2: begin
        if (c) begin
          m_mode = 0; m_rem = m_pre;
        end else if (s) begin
          m_mode = 1;
        end
      end
      default: begin
        if (s || c) begin
          m_mode = 0; m_rem = m_pre;
        end else if (t) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = 0; m_rem = m_pre;
          end
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs on the falling edge and queue the predicted result.
  task automatic cyc(input bit r, t, s, p, c, i, d);
    @(negedge clk);
    rst = r; tick_1hz = t; btn_start = s; btn_pause = p;
    btn_cancel = c; btn_inc = i; btn_dec = d;
    model_step(r, t, s, p, c, i, d);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();   cyc(1, 1, 0, 0, 0, 0, 0); endtask
  task automatic start();  cyc(1, 0, 1, 0, 0, 0, 0); endtask
  task automatic pause();  cyc(1, 0, 0, 1, 0, 0, 0); endtask
  task automatic cancel(); cyc(1, 0, 0, 0, 1, 0, 0); endtask
  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic decs(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: outputs are valid every cycle, so compare each queued prediction
  // just after the edge that should have produced it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("outputs", {state, preset, remaining, buzz, done}, exp_q.pop_front());
    end
  end

  initial begin
    // Reset held for two cycles, then idle.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Full run from preset 3: expiry on third tick, buzzer for three ticks.
    decs(27);
    start();
    idle(1);
    tick(); idle(1); tick(); tick();
    idle(1); tick(); idle(2); tick(); tick();
    idle(2);

    // Pause and resume from preset 5.
    incs(2);
    start();
    tick(); tick();
    pause();
    tick(); tick(); idle(1); tick(); tick();
    start();
    tick();
    cancel();

    // Preset saturation and start/inc collision.
    incs(60);
    decs(70);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 0, 1, 0);
    tick();
    cancel();

    // Priority: pause+tick at remaining 4, cancel+pause, start during alarm.
    incs(5);
    start();
    tick(); tick();
    cyc(1, 1, 0, 1, 0, 0, 0);
    start();
    cyc(1, 0, 0, 1, 1, 0, 0);
    start();
    for (int k = 0; k < 6; k++) tick();
    idle(1);
    start();
    idle(1);

    // Reset mid-run at remaining 7, with a tick in the same cycle.
    incs(1);
    start();
    idle(1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(2);

    // Randomised traffic, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 499) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
